// File: rtl/nanov_pkg.sv
// Shared definitions for the nanoV bit-serial datapath: op encodings and
// default operand/counter widths.
package nanov_pkg;

   localparam int NANOV_WIDTH    = 32;
   localparam int NANOV_CNT_BITS = 5;

   localparam logic [3:0] OP_ADD    = 4'b0000;
   localparam logic [3:0] OP_SUB    = 4'b1000;
   localparam logic [3:0] OP_SLT    = 4'b0010;
   localparam logic [3:0] OP_SLTU   = 4'b0011;
   localparam logic [3:0] OP_XOR    = 4'b0100;
   localparam logic [3:0] OP_OR     = 4'b0110;
   localparam logic [3:0] OP_AND    = 4'b0111;
   localparam logic [3:0] OP_SETLT  = 4'b0001;
   localparam logic [3:0] OP_SETLTU = 4'b1001;

   // Ops that run the adder as a subtractor and therefore refresh the flags.
   function automatic logic is_sub_op(input logic [3:0] op);
      return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
   endfunction

endpackage

// File: rtl/nanov_serial_alu_if.sv
// Per-cycle operand/result bundle between the register file and the serial ALU.
interface nanov_serial_alu_if #(
   parameter int CNT_BITS = 5
);
   logic                en;
   logic [CNT_BITS-1:0] counter;
   logic [3:0]          op;
   logic                a;
   logic                b;
   logic                d;
   logic                cmp_eq;
   logic                cmp_lt;
   logic                cmp_ltu;

   modport master (
      output en, counter, op, a, b,
      input  d, cmp_eq, cmp_lt, cmp_ltu
   );

   modport slave (
      input  en, counter, op, a, b,
      output d, cmp_eq, cmp_lt, cmp_ltu
   );
endinterface

// File: rtl/nanov_serial_adder.sv
// One-bit full adder with a carry flop; carry-in is forced at the first bit
// of a pass so a stale carry never leaks between passes.
module nanov_serial_adder (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic first,
   input  logic a,
   input  logic b,
   input  logic invert_b,
   output logic s,
   output logic cout
);
   logic carry;
   logic cin;
   logic b_eff;

   assign b_eff = b ^ invert_b;
   assign cin   = first ? invert_b : carry;
   assign s     = a ^ b_eff ^ cin;
   assign cout  = (a & b_eff) | (a & cin) | (b_eff & cin);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         carry <= 1'b0;
      end else if (en) begin
         carry <= cout;
      end
   end
endmodule

// File: rtl/nanov_serial_alu.sv
// Bit-serial ALU: combinational result bit per cycle plus registered compare
// flags refreshed at the last bit of every subtract pass.
module nanov_serial_alu
   import nanov_pkg::*;
#(
   parameter int WIDTH    = NANOV_WIDTH,
   parameter int CNT_BITS = NANOV_CNT_BITS
) (
   input logic               clk,
   input logic               rst,
   nanov_serial_alu_if.slave bus
);
   logic first;
   logic last;
   logic sub_op;
   logic s;
   logic cout;
   logic bit_eq;
   logic eq_acc;
   logic cmp_eq;
   logic cmp_lt;
   logic cmp_ltu;

   assign first  = (bus.counter == '0);
   assign last   = (bus.counter == CNT_BITS'(WIDTH - 1));
   assign sub_op = is_sub_op(bus.op);
   assign bit_eq = ~(bus.a ^ bus.b);

   nanov_serial_adder u_adder (
      .clk      (clk),
      .rst      (rst),
      .en       (bus.en),
      .first    (first),
      .a        (bus.a),
      .b        (bus.b),
      .invert_b (sub_op),
      .s        (s),
      .cout     (cout)
   );

   always_comb begin
      bus.d = s;
      case (bus.op)
         OP_XOR:    bus.d = bus.a ^ bus.b;
         OP_OR:     bus.d = bus.a | bus.b;
         OP_AND:    bus.d = bus.a & bus.b;
         OP_SLT,
         OP_SLTU:   bus.d = 1'b0;
         OP_SETLT:  bus.d = first & cmp_lt;
         OP_SETLTU: bus.d = first & cmp_ltu;
         default:   bus.d = s;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         eq_acc <= 1'b0;
      end else if (bus.en) begin
         eq_acc <= first ? bit_eq : (eq_acc & bit_eq);
      end
   end

   // Signed less-than: differing sign bits decide directly, otherwise the
   // sign of the difference does.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmp_eq  <= 1'b0;
         cmp_lt  <= 1'b0;
         cmp_ltu <= 1'b0;
      end else if (bus.en && last && sub_op) begin
         cmp_eq  <= eq_acc & bit_eq;
         cmp_ltu <= ~cout;
         cmp_lt  <= (bus.a != bus.b) ? bus.a : s;
      end
   end

   assign bus.cmp_eq  = cmp_eq;
   assign bus.cmp_lt  = cmp_lt;
   assign bus.cmp_ltu = cmp_ltu;
endmodule

// File: tb/tb_nanov_serial_alu.sv
// Directed bench for nanov_serial_alu: serial passes with hand-computed results.
module tb_nanov_serial_alu;
   import nanov_pkg::*;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;

   nanov_serial_alu_if #(.CNT_BITS(5)) alu_if ();

   nanov_serial_alu #(.WIDTH(32), .CNT_BITS(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (alu_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drives one full pass (counter 0..31) starting at the next negedge and
   // collects d; optional stall of pause_n cycles at counter pause_at.
   task automatic run_pass(input logic [3:0] op_v, input logic [31:0] av,
                           input logic [31:0] bv, input int pause_at,
                           input int pause_n, output logic [31:0] dv);
      dv = '0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         alu_if.op      = op_v;
         alu_if.counter = 5'(i);
         alu_if.a       = av[i];
         alu_if.b       = bv[i];
         if (i == pause_at) begin
            alu_if.en = 1'b0;
            repeat (pause_n) @(negedge clk);
            alu_if.en = 1'b1;
         end
         #1;
         dv[i] = alu_if.d;
      end
   endtask

   task automatic wait_flags();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      alu_if.en = 1'b1; alu_if.op = OP_ADD; alu_if.counter = '0;
      alu_if.a = 1'b1; alu_if.b = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (alu_if.cmp_eq !== 1'b0) begin n_fail++; $display("FAIL reset_eq: got %b want 0", alu_if.cmp_eq); end
      n_cmp++; if (alu_if.cmp_lt !== 1'b0) begin n_fail++; $display("FAIL reset_lt: got %b want 0", alu_if.cmp_lt); end
      n_cmp++; if (alu_if.cmp_ltu !== 1'b0) begin n_fail++; $display("FAIL reset_ltu: got %b want 0", alu_if.cmp_ltu); end
      n_cmp++; if (alu_if.d !== 1'b1) begin n_fail++; $display("FAIL reset_d: got %b want 1", alu_if.d); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_add();
      logic [31:0] dv;
      run_pass(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, -1, 0, dv);
      wait_flags();
      n_cmp++; if (dv !== 32'h8000_0000) begin n_fail++; $display("FAIL add_overflow: got %h want 80000000", dv); end
      n_cmp++; if (alu_if.cmp_eq !== 1'b0) begin n_fail++; $display("FAIL add_flags_hold: got %b want 0", alu_if.cmp_eq); end
   endtask

   task automatic test_sub();
      logic [31:0] dv;
      run_pass(OP_SUB, 32'd5, 32'd7, -1, 0, dv);
      wait_flags();
      n_cmp++; if (dv !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub_5_7: got %h want fffffffe", dv); end
      n_cmp++; if (alu_if.cmp_lt !== 1'b1) begin n_fail++; $display("FAIL sub_5_7_lt: got %b want 1", alu_if.cmp_lt); end
      n_cmp++; if (alu_if.cmp_ltu !== 1'b1) begin n_fail++; $display("FAIL sub_5_7_ltu: got %b want 1", alu_if.cmp_ltu); end
      n_cmp++; if (alu_if.cmp_eq !== 1'b0) begin n_fail++; $display("FAIL sub_5_7_eq: got %b want 0", alu_if.cmp_eq); end
      run_pass(OP_SUB, 32'hFFFF_FFFF, 32'h0000_0001, -1, 0, dv);
      wait_flags();
      n_cmp++; if (dv !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub_m1_1: got %h want fffffffe", dv); end
      n_cmp++; if (alu_if.cmp_lt !== 1'b1) begin n_fail++; $display("FAIL sub_m1_1_lt: got %b want 1", alu_if.cmp_lt); end
      n_cmp++; if (alu_if.cmp_ltu !== 1'b0) begin n_fail++; $display("FAIL sub_m1_1_ltu: got %b want 0", alu_if.cmp_ltu); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d_slt, d_set, d_setu;
      run_pass(OP_SLT, 32'h8000_0000, 32'h0000_0001, -1, 0, d_slt);
      run_pass(OP_SETLT, 32'h8000_0000, 32'h0000_0001, -1, 0, d_set);
      run_pass(OP_SETLTU, 32'h8000_0000, 32'h0000_0001, -1, 0, d_setu);
      n_cmp++; if (d_slt !== 32'h0) begin n_fail++; $display("FAIL slt_d_zero: got %h want 00000000", d_slt); end
      n_cmp++; if (d_set !== 32'h1) begin n_fail++; $display("FAIL setlt: got %h want 00000001", d_set); end
      n_cmp++; if (d_setu !== 32'h0) begin n_fail++; $display("FAIL setltu: got %h want 00000000", d_setu); end
      run_pass(OP_SLTU, 32'h0000_0001, 32'h8000_0000, -1, 0, d_slt);
      run_pass(OP_SETLTU, 32'h0, 32'h0, -1, 0, d_setu);
      n_cmp++; if (d_setu !== 32'h1) begin n_fail++; $display("FAIL sltu_setltu: got %h want 00000001", d_setu); end
   endtask

   task automatic test_pause();
      logic [31:0] d_plain, d_paused;
      run_pass(OP_SUB, 32'h1234, 32'h1234, -1, 0, d_plain);
      run_pass(OP_SUB, 32'h0, 32'h1, -1, 0, d_paused);
      run_pass(OP_SUB, 32'h1234, 32'h1234, 10, 3, d_paused);
      wait_flags();
      n_cmp++; if (d_plain !== 32'h0) begin n_fail++; $display("FAIL sub_eq_plain: got %h want 00000000", d_plain); end
      n_cmp++; if (d_paused !== 32'h0) begin n_fail++; $display("FAIL sub_eq_paused: got %h want 00000000", d_paused); end
      n_cmp++; if (alu_if.cmp_eq !== 1'b1) begin n_fail++; $display("FAIL paused_eq: got %b want 1", alu_if.cmp_eq); end
      n_cmp++; if (alu_if.cmp_ltu !== 1'b0) begin n_fail++; $display("FAIL paused_ltu: got %b want 0", alu_if.cmp_ltu); end
      n_cmp++; if (alu_if.cmp_lt !== 1'b0) begin n_fail++; $display("FAIL paused_lt: got %b want 0", alu_if.cmp_lt); end
   endtask

   task automatic test_logic();
      logic [31:0] dv;
      run_pass(OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, -1, 0, dv);
      wait_flags();
      n_cmp++; if (dv !== 32'h0FF0_0FF0) begin n_fail++; $display("FAIL xor: got %h want 0ff00ff0", dv); end
      n_cmp++; if (alu_if.cmp_eq !== 1'b1) begin n_fail++; $display("FAIL xor_flags_hold: got %b want 1", alu_if.cmp_eq); end
      run_pass(OP_OR, 32'hF0F0_F0F0, 32'h0F00_00FF, -1, 0, dv);
      n_cmp++; if (dv !== 32'hFFF0_F0FF) begin n_fail++; $display("FAIL or: got %h want fff0f0ff", dv); end
      run_pass(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, -1, 0, dv);
      n_cmp++; if (dv !== 32'hF000_F000) begin n_fail++; $display("FAIL and: got %h want f000f000", dv); end
      run_pass(4'b0101, 32'd10, 32'd20, -1, 0, dv);
      wait_flags();
      n_cmp++; if (dv !== 32'd30) begin n_fail++; $display("FAIL undef_op_add: got %h want 0000001e", dv); end
      n_cmp++; if (alu_if.cmp_eq !== 1'b1) begin n_fail++; $display("FAIL undef_op_flags_hold: got %b want 1", alu_if.cmp_eq); end
   endtask

   task automatic test_reset_mid_pass();
      logic [31:0] dv;
      for (int i = 0; i <= 17; i++) begin
         @(negedge clk);
         alu_if.op = OP_SUB; alu_if.counter = 5'(i);
         alu_if.a = 1'b0; alu_if.b = (i == 0);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (alu_if.cmp_eq !== 1'b0) begin n_fail++; $display("FAIL midrst_eq: got %b want 0", alu_if.cmp_eq); end
      n_cmp++; if (alu_if.cmp_lt !== 1'b0) begin n_fail++; $display("FAIL midrst_lt: got %b want 0", alu_if.cmp_lt); end
      n_cmp++; if (alu_if.cmp_ltu !== 1'b0) begin n_fail++; $display("FAIL midrst_ltu: got %b want 0", alu_if.cmp_ltu); end
      @(negedge clk);
      rst = 1'b0;
      run_pass(OP_ADD, 32'd3, 32'd4, -1, 0, dv);
      wait_flags();
      n_cmp++; if (dv !== 32'd7) begin n_fail++; $display("FAIL post_rst_add: got %h want 00000007", dv); end
      n_cmp++; if (alu_if.cmp_eq !== 1'b0) begin n_fail++; $display("FAIL post_rst_eq: got %b want 0", alu_if.cmp_eq); end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_add();
      test_sub();
      test_back_to_back();
      test_pause();
      test_logic();
      test_reset_mid_pass();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
